// File: rtl/cnn_seq_pkg.sv
// Shared definitions for the CNN job sequencer: state codes, error bit
// positions and the default job geometry.
package cnn_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_L = 3'd2,
        ST_START  = 3'd3,
        ST_RUN    = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    // Bit positions inside the sticky err vector {count, overflow, timeout}
    localparam int ERR_TIMEOUT  = 0;
    localparam int ERR_OVERFLOW = 1;
    localparam int ERR_COUNT    = 2;

    localparam int DEF_W_COUNT        = 144;
    localparam int DEF_L_COUNT        = 32;
    localparam int DEF_R_COUNT        = 8;
    localparam int DEF_RFIFO_DEPTH    = 8;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cnn_result_fifo.sv
// Show-ahead result FIFO: the head entry is visible on head_data whenever
// the FIFO is not empty. head_data reads as zero while empty so nothing
// stale leaks out after reset or flush. DEPTH must be a power of two.
module cnn_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign do_pop    = pop && !empty;
    // A push onto a full FIFO succeeds only when a pop frees a slot in the same cycle
    assign do_push   = push && (!full || do_pop);
    assign head_data = empty ? '0 : mem[rd_ptr_reg];

    // Storage array, written only; no reset so it maps onto distributed RAM
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/cnn_job_sequencer.sv
// Job sequencer between the host byte stream and the CNN accelerator:
// streams weights then line bytes into the serial load ports, pulses start,
// collects result bytes into a show-ahead FIFO and reports errors.
module cnn_job_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int W_COUNT        = DEF_W_COUNT,
    parameter int L_COUNT        = DEF_L_COUNT,
    parameter int R_COUNT        = DEF_R_COUNT,
    parameter int RFIFO_DEPTH    = DEF_RFIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_go,
    input  logic       cmd_abort,
    input  logic [7:0] host_data,
    input  logic       host_valid,
    output logic       host_ready,
    output logic [7:0] acc_weight_data,
    output logic       acc_weight_valid,
    output logic [7:0] acc_line_data,
    output logic       acc_line_valid,
    output logic       acc_start,
    input  logic [7:0] acc_result,
    input  logic       acc_result_valid,
    input  logic       acc_done,
    output logic [7:0] res_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       busy,
    output logic       job_done,
    output logic [2:0] err,
    output logic [2:0] state
);

    localparam int BW = $clog2(max_int(W_COUNT, L_COUNT) + 1);
    localparam int RW = $clog2(R_COUNT + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BW-1:0] W_LAST  = BW'(W_COUNT - 1);
    localparam logic [BW-1:0] L_LAST  = BW'(L_COUNT - 1);
    localparam logic [RW-1:0] R_EXP   = RW'(R_COUNT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state_reg, state_next;
    logic [BW-1:0] byte_cnt_reg, byte_cnt_next;
    logic [RW-1:0] res_cnt_reg, res_cnt_next;
    logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic [2:0]    err_reg, err_next;
    logic [7:0]    wdata_reg, wdata_next;
    logic          wvalid_reg, wvalid_next;
    logic [7:0]    ldata_reg, ldata_next;
    logic          lvalid_reg, lvalid_next;
    logic          start_reg, start_next;
    logic          job_done_reg, job_done_next;

    logic accept;
    logic capture;
    logic fifo_push;
    logic fifo_full;
    logic fifo_empty;
    logic overflow;

    assign host_ready = (state_reg == ST_LOAD_W) || (state_reg == ST_LOAD_L);
    assign accept     = host_valid && host_ready;
    assign capture    = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign fifo_push  = capture && acc_result_valid && !cmd_abort;
    // A same-cycle host pop (only possible when not empty) makes room on a full FIFO
    assign overflow   = fifo_push && fifo_full && !res_ready;

    assign busy             = (state_reg != ST_IDLE);
    assign state            = state_reg;
    assign err              = err_reg;
    assign job_done         = job_done_reg;
    assign acc_weight_data  = wdata_reg;
    assign acc_weight_valid = wvalid_reg;
    assign acc_line_data    = ldata_reg;
    assign acc_line_valid   = lvalid_reg;
    assign acc_start        = start_reg;
    assign res_valid        = !fifo_empty;

    cnn_result_fifo #(
        .DEPTH (RFIFO_DEPTH),
        .WIDTH (8)
    ) u_result_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (cmd_abort),
        .push      (fifo_push),
        .push_data (acc_result),
        .pop       (res_ready),
        .head_data (res_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State, counters and registered accelerator-side outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            byte_cnt_reg <= '0;
            res_cnt_reg  <= '0;
            tmo_cnt_reg  <= '0;
            err_reg      <= '0;
            wdata_reg    <= '0;
            wvalid_reg   <= 1'b0;
            ldata_reg    <= '0;
            lvalid_reg   <= 1'b0;
            start_reg    <= 1'b0;
            job_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            res_cnt_reg  <= res_cnt_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            err_reg      <= err_next;
            wdata_reg    <= wdata_next;
            wvalid_reg   <= wvalid_next;
            ldata_reg    <= ldata_next;
            lvalid_reg   <= lvalid_next;
            start_reg    <= start_next;
            job_done_reg <= job_done_next;
        end
    end

    // Next-state logic, counter updates and output pulse generation
    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        res_cnt_next  = res_cnt_reg;
        tmo_cnt_next  = tmo_cnt_reg;
        err_next      = err_reg;
        wdata_next    = wdata_reg;
        wvalid_next   = 1'b0;
        ldata_next    = ldata_reg;
        lvalid_next   = 1'b0;
        start_next    = 1'b0;
        job_done_next = 1'b0;

        // Every result strobe counts, even one the FIFO has to drop; saturates
        if (fifo_push && (res_cnt_reg != '1)) begin
            res_cnt_next = res_cnt_reg + RW'(1);
        end

        case (state_reg)
            ST_IDLE: begin
                if (cmd_go) begin
                    state_next    = ST_LOAD_W;
                    byte_cnt_next = '0;
                    res_cnt_next  = '0;
                    tmo_cnt_next  = '0;
                    err_next      = '0;
                end
            end
            ST_LOAD_W: begin
                if (accept) begin
                    wdata_next  = host_data;
                    wvalid_next = 1'b1;
                    if (byte_cnt_reg == W_LAST) begin
                        state_next    = ST_LOAD_L;
                        byte_cnt_next = '0;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + BW'(1);
                    end
                end
            end
            ST_LOAD_L: begin
                if (accept) begin
                    ldata_next  = host_data;
                    lvalid_next = 1'b1;
                    if (byte_cnt_reg == L_LAST) begin
                        state_next    = ST_START;
                        byte_cnt_next = '0;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + BW'(1);
                    end
                end
            end
            ST_START: begin
                start_next   = 1'b1;
                state_next   = ST_RUN;
                tmo_cnt_next = '0;
            end
            ST_RUN: begin
                // acc_done takes priority over a timeout in the same cycle
                if (acc_done) begin
                    state_next = ST_DRAIN;
                end else if (tmo_cnt_reg == TO_LAST) begin
                    state_next            = ST_ERROR;
                    err_next[ERR_TIMEOUT] = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + TW'(1);
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_next    = ST_IDLE;
                    job_done_next = 1'b1;
                    if (res_cnt_next != R_EXP) begin
                        err_next[ERR_COUNT] = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                state_next = ST_ERROR;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (overflow) begin
            err_next[ERR_OVERFLOW] = 1'b1;
        end

        // Abort wins over everything; err is deliberately kept for the host
        if (cmd_abort) begin
            state_next    = ST_IDLE;
            byte_cnt_next = '0;
            tmo_cnt_next  = '0;
            wvalid_next   = 1'b0;
            lvalid_next   = 1'b0;
            start_next    = 1'b0;
            job_done_next = 1'b0;
        end
    end

endmodule

// File: tb/tb_cnn_job_sequencer.sv
// Self-checking bench for cnn_job_sequencer: scoreboard queues hold the
// expected load-port bytes and result bytes; one task per scenario.
module tb_cnn_job_sequencer;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;
    localparam int         NW       = 144;
    localparam int         NB       = 176;

    typedef struct packed {
        logic       line;
        logic [7:0] data;
    } beat_t;

    logic       clk;
    logic       reset_n;
    logic       cmd_go;
    logic       cmd_abort;
    logic [7:0] host_data;
    logic       host_valid;
    logic       host_ready;
    logic [7:0] acc_weight_data;
    logic       acc_weight_valid;
    logic [7:0] acc_line_data;
    logic       acc_line_valid;
    logic       acc_start;
    logic [7:0] acc_result;
    logic       acc_result_valid;
    logic       acc_done;
    logic [7:0] res_data;
    logic       res_valid;
    logic       res_ready;
    logic       busy;
    logic       job_done;
    logic [2:0] err;
    logic [2:0] state;
    logic [36:0] all_out;

    int vec_cnt;
    int mis_cnt;
    beat_t      exp_q[$];
    logic [7:0] res_q[$];

    assign all_out = {state, busy, host_ready, acc_weight_data, acc_weight_valid,
                      acc_line_data, acc_line_valid, acc_start, res_data,
                      res_valid, job_done, err};

    cnn_job_sequencer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cmd_go           (cmd_go),
        .cmd_abort        (cmd_abort),
        .host_data        (host_data),
        .host_valid       (host_valid),
        .host_ready       (host_ready),
        .acc_weight_data  (acc_weight_data),
        .acc_weight_valid (acc_weight_valid),
        .acc_line_data    (acc_line_data),
        .acc_line_valid   (acc_line_valid),
        .acc_start        (acc_start),
        .acc_result       (acc_result),
        .acc_result_valid (acc_result_valid),
        .acc_done         (acc_done),
        .res_data         (res_data),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .busy             (busy),
        .job_done         (job_done),
        .err              (err),
        .state            (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pat(input int s);
        return (s < NW) ? 8'(s) : 8'(160 + s - NW);
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; cmd_go = 1'b0; cmd_abort = 1'b0;
        host_data = '0; host_valid = 1'b0;
        acc_result = '0; acc_result_valid = 1'b0; acc_done = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if (all_out !== '0) begin
            mis_cnt++; $display("FAIL reset_outputs: got %h, required 0", all_out);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        vec_cnt++;
        if (state !== S_IDLE) begin
            mis_cnt++; $display("FAIL reset_state: got %0d, required %0d", state, S_IDLE);
        end
    endtask

    task automatic start_job();
        cmd_go = 1'b1;
        @(posedge clk); #1;
        cmd_go = 1'b0;
        vec_cnt++;
        if (state !== S_LOAD_W || err !== 3'b000 || busy !== 1'b1) begin
            mis_cnt++;
            $display("FAIL start_job: state %0d err %b busy %b, required 1 000 1", state, err, busy);
        end
    endtask

    // Streams n bytes, checking each load-port valid against the scoreboard
    task automatic load_bytes(input int n, input bit throttle);
        bit    prev_acc;
        bit    ph;
        int    sent;
        int    guard;
        beat_t exp_b;
        beat_t got_b;
        beat_t new_b;
        prev_acc = 1'b0; ph = 1'b1; sent = 0; guard = 0;
        host_valid = 1'b1; host_data = pat(0);
        while ((sent < n || prev_acc) && guard < 2000) begin
            @(negedge clk);
            vec_cnt++;
            if ((acc_weight_valid | acc_line_valid) !== prev_acc) begin
                mis_cnt++;
                $display("FAIL load_valid: byte %0d valid w=%b l=%b, required %b",
                         sent, acc_weight_valid, acc_line_valid, prev_acc);
            end
            if (prev_acc && exp_q.size() > 0) begin
                exp_b = exp_q.pop_front();
                got_b.line = acc_line_valid;
                got_b.data = acc_line_valid ? acc_line_data : acc_weight_data;
                vec_cnt++;
                if (got_b !== exp_b) begin
                    mis_cnt++;
                    $display("FAIL load_byte: got line=%b data=%h, required line=%b data=%h",
                             got_b.line, got_b.data, exp_b.line, exp_b.data);
                end
            end
            vec_cnt++;
            if (acc_start !== 1'b0) begin
                mis_cnt++; $display("FAIL load_start_early: got %b, required 0", acc_start);
            end
            if (host_valid) begin
                vec_cnt++;
                if (host_ready !== 1'b1) begin
                    mis_cnt++; $display("FAIL load_ready: byte %0d got %b, required 1", sent, host_ready);
                end
                new_b.line = (sent >= NW);
                new_b.data = pat(sent);
                exp_q.push_back(new_b);
                sent++;
            end
            prev_acc = host_valid;
            @(posedge clk); #1;
            guard++;
            ph = throttle ? ~ph : 1'b1;
            host_valid = (sent < n) && ph;
            host_data = pat(sent);
        end
        host_valid = 1'b0;
        vec_cnt++;
        if (guard >= 2000) begin
            mis_cnt++; $display("FAIL load_timeout: sent %0d, required %0d", sent, n);
        end
    endtask

    // Called in the cycle two after the last accepted byte
    task automatic check_start_pulse();
        @(negedge clk);
        vec_cnt++;
        if (acc_start !== 1'b1 || state !== S_RUN) begin
            mis_cnt++; $display("FAIL start_pulse: start %b state %0d, required 1 4", acc_start, state);
        end
        @(negedge clk);
        vec_cnt++;
        if (acc_start !== 1'b0) begin
            mis_cnt++; $display("FAIL start_width: got %b, required 0", acc_start);
        end
        @(posedge clk); #1;
    endtask

    // Accelerator model emits n_res results then acc_done; host reads FIFO
    task automatic run_phase(input int n_res, input int keep, input bit rd_during,
                             input logic [2:0] err_mid, input logic [2:0] err_fin);
        int         c;
        int         jd;
        logic [7:0] e;
        c = 0; jd = 0;
        while (jd == 0 && c < 300) begin
            acc_result_valid = (c < n_res);
            acc_result       = 8'(16 + c);
            acc_done         = (c == n_res);
            res_ready        = rd_during || (c > n_res);
            if (c < n_res && c < keep) res_q.push_back(8'(16 + c));
            @(negedge clk);
            if (res_ready && res_valid) begin
                vec_cnt++;
                if (res_q.size() == 0) begin
                    mis_cnt++; $display("FAIL res_unexpected: got %h, required no data", res_data);
                end else begin
                    e = res_q.pop_front();
                    if (res_data !== e) begin
                        mis_cnt++; $display("FAIL res_data: got %h, required %h", res_data, e);
                    end
                end
            end
            if (c == n_res + 1) begin
                vec_cnt++;
                if (state !== S_DRAIN || err !== err_mid) begin
                    mis_cnt++;
                    $display("FAIL drain_entry: state %0d err %b, required %0d %b", state, err, S_DRAIN, err_mid);
                end
            end
            if (job_done === 1'b1) jd++;
            @(posedge clk); #1;
            c++;
        end
        acc_result_valid = 1'b0; acc_done = 1'b0; res_ready = 1'b0;
        vec_cnt++;
        if (state !== S_IDLE || err !== err_fin || res_valid !== 1'b0 || res_q.size() != 0) begin
            mis_cnt++;
            $display("FAIL job_end: state %0d err %b res_valid %b left %0d, required 0 %b 0 0",
                     state, err, res_valid, res_q.size(), err_fin);
        end
        repeat (3) begin
            @(negedge clk);
            if (job_done === 1'b1) jd++;
        end
        vec_cnt++;
        if (jd != 1) begin
            mis_cnt++; $display("FAIL job_done_count: got %0d, required 1", jd);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_nominal();
        start_job();
        load_bytes(NB, 1'b0);
        check_start_pulse();
        run_phase(8, 8, 1'b1, 3'b000, 3'b000);
    endtask

    task automatic test_throttled();
        start_job();
        load_bytes(NB, 1'b1);
        check_start_pulse();
        run_phase(8, 8, 1'b0, 3'b000, 3'b000);
    endtask

    task automatic test_overflow();
        start_job();
        load_bytes(NB, 1'b0);
        check_start_pulse();
        run_phase(10, 8, 1'b0, 3'b010, 3'b110);
    endtask

    task automatic test_timeout();
        int run_cyc;
        start_job();
        load_bytes(NB, 1'b0);
        run_cyc = 0;
        while (run_cyc < 5000) begin
            @(negedge clk);
            if (state !== S_RUN) break;
            run_cyc++;
        end
        vec_cnt++;
        if (run_cyc != 4096) begin
            mis_cnt++; $display("FAIL timeout_cycles: got %0d, required 4096", run_cyc);
        end
        vec_cnt++;
        if (state !== S_ERROR || err !== 3'b001 || busy !== 1'b1) begin
            mis_cnt++; $display("FAIL timeout_error: state %0d err %b busy %b, required 6 001 1", state, err, busy);
        end
        @(posedge clk); #1;
        cmd_go = 1'b1;
        @(posedge clk); #1;
        cmd_go = 1'b0;
        vec_cnt++;
        if (state !== S_ERROR) begin
            mis_cnt++; $display("FAIL error_ignores_go: state %0d, required 6", state);
        end
        cmd_abort = 1'b1;
        @(posedge clk); #1;
        cmd_abort = 1'b0;
        vec_cnt++;
        if (state !== S_IDLE || err !== 3'b001 || busy !== 1'b0) begin
            mis_cnt++; $display("FAIL error_abort: state %0d err %b busy %b, required 0 001 0", state, err, busy);
        end
    endtask

    task automatic test_abort_mid_load();
        start_job();
        load_bytes(50, 1'b0);
        host_valid = 1'b1; host_data = pat(50); cmd_abort = 1'b1;
        @(posedge clk); #1;
        cmd_abort = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (host_ready !== 1'b0 || acc_weight_valid !== 1'b0 || acc_line_valid !== 1'b0 ||
            busy !== 1'b0 || state !== S_IDLE) begin
            mis_cnt++;
            $display("FAIL abort_load: ready %b wv %b lv %b busy %b state %0d, required 0 0 0 0 0",
                     host_ready, acc_weight_valid, acc_line_valid, busy, state);
        end
        repeat (5) begin
            @(negedge clk);
            vec_cnt++;
            if (acc_start !== 1'b0 || acc_weight_valid !== 1'b0 || acc_line_valid !== 1'b0) begin
                mis_cnt++;
                $display("FAIL abort_quiet: start %b wv %b lv %b, required 0 0 0",
                         acc_start, acc_weight_valid, acc_line_valid);
            end
        end
        host_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        start_job();
        load_bytes(NB, 1'b0);
        for (int i = 0; i < 3; i++) begin
            acc_result_valid = 1'b1;
            acc_result = 8'(32 + i);
            @(posedge clk); #1;
        end
        acc_result_valid = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (res_valid !== 1'b1 || res_data !== 8'h20) begin
            mis_cnt++; $display("FAIL pre_reset_fifo: valid %b data %h, required 1 20", res_valid, res_data);
        end
        #2 reset_n = 1'b0;
        #1;
        vec_cnt++;
        if (all_out !== '0) begin
            mis_cnt++; $display("FAIL async_reset: got %h, required 0", all_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vec_cnt++;
            if (job_done !== 1'b0 || res_valid !== 1'b0 || state !== S_IDLE) begin
                mis_cnt++;
                $display("FAIL post_reset: job_done %b res_valid %b state %0d, required 0 0 0",
                         job_done, res_valid, state);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vec_cnt = 0;
        mis_cnt = 0;
        test_reset();
        test_nominal();
        test_throttled();
        test_overflow();
        test_timeout();
        test_abort_mid_load();
        test_async_reset();
        test_nominal();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
